// File: rtl/wb_pkg.sv
// Shared types and helpers for the output write-back DMA.
// DRAM word address = {row, col}; the FSM state enum lives here.
package wb_pkg;
  localparam int ROW_W  = 13;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 23;

  typedef logic [ADDR_W-1:0] dram_addr_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ROWCHK,
    S_PRE,
    S_ACT,
    S_WRITE,
    S_PREF,
    S_DONE
  } wb_state_t;

  function automatic logic [ROW_W-1:0] row_of(
    dram_addr_t a,
    int col_w
  );
    dram_addr_t s;
    s = a >> col_w;
    return s[ROW_W-1:0];
  endfunction

  function automatic logic [ROW_W-1:0] col_of(
    dram_addr_t a,
    int col_w
  );
    dram_addr_t m;
    m = (dram_addr_t'(1) << col_w) - dram_addr_t'(1);
    m = a & m;
    return m[ROW_W-1:0];
  endfunction
endpackage

// File: rtl/maxpool_acc.sv
// Signed running-max register: load takes the first tap,
// valid folds in later taps, clr empties it.
module maxpool_acc
  import wb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic              valid,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] max_q
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      max_q <= '0;
    end else if (clr) begin
      max_q <= '0;
    end else if (load) begin
      max_q <= din;
    end else if (valid) begin
      if ($signed(din) > $signed(max_q))
        max_q <= din;
    end
  end
endmodule

// File: rtl/output_writeback_dma.sv
// Output write-back DMA: drains per-kernel output SRAMs into DRAM,
// optionally applying 2x2/stride-2 signed max-pooling on the fly.
module output_writeback_dma
  import wb_pkg::*;
#(
  parameter int NUM_BANKS  = 32,
  parameter int SRAM_DEPTH = 4096,
  parameter int COL_W      = 10,
  parameter int T_RCD      = 1,
  parameter int T_RP       = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [ADDR_W-1:0]             base_addr,
  input  logic [9:0]                    map_size,
  input  logic [9:0]                    kernel_num,
  input  logic                          pooling,
  output logic                          busy,
  output logic                          done,
  output logic                          sram_rd_en,
  output logic [$clog2(NUM_BANKS)-1:0]  sram_bank,
  output logic [$clog2(SRAM_DEPTH)-1:0] sram_addr,
  input  logic [DATA_W-1:0]             sram_rdata,
  output logic                          CSn,
  output logic                          RASn,
  output logic                          CASn,
  output logic [3:0]                    WEn,
  output logic [ROW_W-1:0]              A,
  output logic [DATA_W-1:0]             D
);
  localparam int BANK_W  = $clog2(NUM_BANKS);
  localparam int SRAM_AW = $clog2(SRAM_DEPTH);
  localparam int SB_W    = 21;
  localparam int CNT_W   = 8;

  wb_state_t         state;
  logic [2:0]        tap;
  logic [CNT_W-1:0]  cnt;
  logic              rd_pend;
  dram_addr_t        daddr;
  logic [9:0]        ms_q, m_q, kn_q;
  logic [9:0]        x, y, c;
  logic              pool_q;
  logic [SB_W-1:0]   sbase;
  logic              row_open;
  logic [ROW_W-1:0]  open_row;
  logic [DATA_W-1:0] word_q, acc_max, word;
  logic              acc_clr, acc_load, acc_vld;
  logic [9:0]        m_in, nx, ny, nc;
  logic [SB_W-1:0]   nsb, step;
  logic              x_last, y_last, last_word;
  logic [ROW_W-1:0]  cur_row, cur_col;

  // Tap address: pool taps walk (2y,2x) .. (2y+1,2x+1).
  function automatic logic [SB_W-1:0] taddr(
    logic [SB_W-1:0] sb,
    logic [9:0]      xx,
    logic [1:0]      t
  );
    logic [SB_W-1:0] a;
    if (pool_q)
      a = sb + (t[1] ? SB_W'(ms_q) : '0)
          + SB_W'({xx, t[0]});
    else
      a = sb + SB_W'(xx);
    return a;
  endfunction

  assign m_in = pooling ? {1'b0, map_size[9:1]}
                        : map_size;
  assign step = pool_q ? SB_W'({ms_q, 1'b0})
                       : SB_W'(ms_q);
  assign word    = pool_q ? acc_max : word_q;
  assign cur_row = row_of(daddr, COL_W);
  assign cur_col = col_of(daddr, COL_W);

  always_comb begin
    x_last    = (x == m_q - 10'd1);
    y_last    = (y == m_q - 10'd1);
    last_word = x_last && y_last
                && (c == kn_q - 10'd1);
    nx  = x_last ? '0 : x + 10'd1;
    ny  = y;
    nc  = c;
    nsb = sbase;
    if (x_last) begin
      ny  = y + 10'd1;
      nsb = sbase + step;
      if (y_last) begin
        ny  = '0;
        nsb = '0;
        nc  = c + 10'd1;
      end
    end
  end

  always_comb begin
    acc_clr  = (state == S_IDLE) && start;
    acc_load = 1'b0;
    acc_vld  = 1'b0;
    if (state == S_FETCH && rd_pend && pool_q) begin
      acc_load = (tap == 3'd1);
      acc_vld  = (tap != 3'd1);
    end
  end

  maxpool_acc u_acc (
    .clk   (clk),
    .rst   (rst),
    .clr   (acc_clr),
    .load  (acc_load),
    .valid (acc_vld),
    .din   (sram_rdata),
    .max_q (acc_max)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      tap        <= '0;
      cnt        <= '0;
      rd_pend    <= 1'b0;
      daddr      <= '0;
      ms_q       <= '0;
      m_q        <= '0;
      kn_q       <= '0;
      pool_q     <= 1'b0;
      x          <= '0;
      y          <= '0;
      c          <= '0;
      sbase      <= '0;
      row_open   <= 1'b0;
      open_row   <= '0;
      word_q     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sram_rd_en <= 1'b0;
      sram_bank  <= '0;
      sram_addr  <= '0;
      CSn        <= 1'b1;
      RASn       <= 1'b1;
      CASn       <= 1'b1;
      WEn        <= 4'hF;
      A          <= '0;
      D          <= '0;
    end else begin
      rd_pend <= sram_rd_en;
      if (rd_pend)
        word_q <= sram_rdata;
      unique case (state)
        S_IDLE: if (start) begin
          daddr     <= base_addr;
          ms_q      <= map_size;
          m_q       <= m_in;
          kn_q      <= kernel_num;
          pool_q    <= pooling;
          x         <= '0;
          y         <= '0;
          c         <= '0;
          sbase     <= '0;
          tap       <= '0;
          sram_bank <= '0;
          sram_addr <= '0;
          if (kernel_num == '0 || m_in == '0) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            busy       <= 1'b1;
            sram_rd_en <= 1'b1;
            state      <= S_FETCH;
          end
        end
        S_FETCH: begin
          tap        <= tap + 3'd1;
          sram_rd_en <= 1'b0;
          if (pool_q && tap < 3'd3) begin
            sram_rd_en <= 1'b1;
            sram_addr  <= SRAM_AW'(taddr(sbase, x,
                            tap[1:0] + 2'd1));
          end
          if (tap == (pool_q ? 3'd4 : 3'd1))
            state <= S_ROWCHK;
        end
        S_ROWCHK: begin
          if (row_open && open_row == cur_row) begin
            CSn   <= 1'b0;
            CASn  <= 1'b0;
            WEn   <= 4'h0;
            A     <= cur_col;
            D     <= word;
            state <= S_WRITE;
          end else if (row_open) begin
            CSn      <= 1'b0;
            RASn     <= 1'b1;
            row_open <= 1'b0;
            cnt      <= '0;
            state    <= S_PRE;
          end else begin
            CSn      <= 1'b0;
            RASn     <= 1'b0;
            A        <= cur_row;
            row_open <= 1'b1;
            open_row <= cur_row;
            cnt      <= '0;
            state    <= S_ACT;
          end
        end
        S_PRE: begin
          if (cnt == CNT_W'(T_RP - 1)) begin
            RASn     <= 1'b0;
            A        <= cur_row;
            row_open <= 1'b1;
            open_row <= cur_row;
            cnt      <= '0;
            state    <= S_ACT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_ACT: begin
          CSn <= 1'b1;
          if (cnt == CNT_W'(T_RCD)) begin
            CSn   <= 1'b0;
            CASn  <= 1'b0;
            WEn   <= 4'h0;
            A     <= cur_col;
            D     <= word;
            state <= S_WRITE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WRITE: begin
          CSn   <= 1'b1;
          CASn  <= 1'b1;
          WEn   <= 4'hF;
          daddr <= daddr + 1'b1;
          x     <= nx;
          y     <= ny;
          c     <= nc;
          sbase <= nsb;
          if (last_word) begin
            CSn      <= 1'b0;
            RASn     <= 1'b1;
            row_open <= 1'b0;
            cnt      <= '0;
            state    <= S_PREF;
          end else begin
            tap        <= '0;
            sram_rd_en <= 1'b1;
            sram_bank  <= nc[BANK_W-1:0];
            sram_addr  <= SRAM_AW'(taddr(nsb, nx, 2'd0));
            state      <= S_FETCH;
          end
        end
        S_PREF: begin
          if (cnt == CNT_W'(T_RP - 1)) begin
            CSn   <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_output_writeback_dma.sv
// Bench for output_writeback_dma: SRAM model, DRAM command monitor
// and a loop-based reference of the expected word stream.
module tb_output_writeback_dma;
  localparam int NB    = 4;
  localparam int DEPTH = 64;
  localparam int COLW  = 10;
  localparam int TRCD  = 1;
  localparam int TRP   = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [22:0] base_addr;
  logic [9:0]  map_size;
  logic [9:0]  kernel_num;
  logic        pooling;
  logic        busy, done, sram_rd_en;
  logic [1:0]  sram_bank;
  logic [5:0]  sram_addr;
  logic [31:0] sram_rdata;
  logic        CSn, RASn, CASn;
  logic [3:0]  WEn;
  logic [12:0] A;
  logic [31:0] D;

  always #5 clk = ~clk;

  output_writeback_dma #(
    .NUM_BANKS  (NB),
    .SRAM_DEPTH (DEPTH),
    .COL_W      (COLW),
    .T_RCD      (TRCD),
    .T_RP       (TRP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .map_size   (map_size),
    .kernel_num (kernel_num),
    .pooling    (pooling),
    .busy       (busy),
    .done       (done),
    .sram_rd_en (sram_rd_en),
    .sram_bank  (sram_bank),
    .sram_addr  (sram_addr),
    .sram_rdata (sram_rdata),
    .CSn        (CSn),
    .RASn       (RASn),
    .CASn       (CASn),
    .WEn        (WEn),
    .A          (A),
    .D          (D)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [NB][DEPTH];
  int reads, bad_reads, pw, wms, wm;

  always @(posedge clk) begin
    if (sram_rd_en) begin
      sram_rdata <= mem[sram_bank][sram_addr];
      reads++;
      if (pw != 0 && ((int'(sram_addr) % wms) >= 2 * wm ||
                      (int'(sram_addr) / wms) >= 2 * wm))
        bad_reads++;
    end
  end

  logic [22:0] wa[$];
  logic [31:0] wd[$];
  logic [12:0] act_rows[$];
  logic [22:0] exp_a[$];
  logic [31:0] exp_d[$];
  int act_cnt, pre_cycles, done_cnt, viol, cs_cycles, since_act;
  logic [12:0] mon_row;
  logic        mon_open = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      mon_open = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (!CSn) cs_cycles++;
      since_act++;
      if (!CSn && !RASn && CASn) begin
        act_cnt++;
        mon_row = A;
        mon_open = 1'b1;
        since_act = 0;
        act_rows.push_back(A);
      end
      if (!CSn && RASn && CASn) begin
        pre_cycles++;
        mon_open = 1'b0;
      end
      if (!CSn && !CASn) begin
        if (WEn != 4'h0 || !mon_open || RASn ||
            since_act <= TRCD || A[12:COLW] != '0)
          viol++;
        wa.push_back({mon_row, A[COLW-1:0]});
        wd.push_back(D);
      end
      if (RASn == mon_open) viol++;
    end
  end

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, expv);
    end
  endtask

  task automatic build_exp(input logic [22:0] b, input int ms,
                           input int kn, input int pl,
                           output int nw, output int na);
    int m, r, prev;
    logic signed [31:0] mx, v;
    logic [22:0] a;
    exp_a.delete();
    exp_d.delete();
    m = pl != 0 ? ms / 2 : ms;
    na = 0;
    prev = -1;
    for (int ch = 0; ch < kn; ch++)
      for (int yy = 0; yy < m; yy++)
        for (int xx = 0; xx < m; xx++) begin
          if (pl == 0) begin
            v = mem[ch][yy * ms + xx];
          end else begin
            mx = mem[ch][2 * yy * ms + 2 * xx];
            for (int t = 1; t < 4; t++) begin
              v = mem[ch][(2 * yy + t / 2) * ms + 2 * xx + t % 2];
              if (v > mx) mx = v;
            end
            v = mx;
          end
          a = b + 23'(exp_a.size());
          exp_a.push_back(a);
          exp_d.push_back(v);
          r = int'(a >> COLW);
          if (r != prev) na++;
          prev = r;
        end
    nw = exp_a.size();
  endtask

  task automatic run_job(input string nm, input logic [22:0] b,
                         input int ms, input int kn, input int pl,
                         input int inj, input int ew, input int ea,
                         output int lat);
    int nw, na, cyc;
    build_exp(b, ms, kn, pl, nw, na);
    if (ew < 0) ew = nw;
    if (ea < 0) ea = na;
    @(negedge clk);
    wa.delete(); wd.delete(); act_rows.delete();
    act_cnt = 0; pre_cycles = 0; done_cnt = 0; viol = 0;
    cs_cycles = 0; since_act = 0; reads = 0; bad_reads = 0;
    wm = pl != 0 ? ms / 2 : ms;
    wms = ms;
    pw = (pl != 0 && wm > 0) ? 1 : 0;
    base_addr = b; map_size = 10'(ms); kernel_num = 10'(kn);
    pooling = pl[0]; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    if (ew > 0) chk({nm, "_busy"}, 64'(busy), 64'd1);
    while (!done && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (inj != 0 && cyc == 5) begin
        start = 1'b1; kernel_num = 10'd4; map_size = 10'd7;
        pooling = 1'b0; base_addr = '0;
      end else begin
        start = 1'b0;
      end
    end
    lat = cyc;
    chk({nm, "_timeout"}, 64'(done), 64'd1);
    repeat (3) @(negedge clk);
    chk({nm, "_busy_end"}, 64'(busy), 64'd0);
    chk({nm, "_done_pulses"}, 64'(done_cnt), 64'd1);
    chk({nm, "_writes"}, 64'(wa.size()), 64'(ew));
    chk({nm, "_acts"}, 64'(act_cnt), 64'(ea));
    chk({nm, "_pre_cycles"}, 64'(pre_cycles), 64'(TRP * ea));
    chk({nm, "_protocol"}, 64'(viol), 64'd0);
    chk({nm, "_reads"}, 64'(reads), 64'(nw * (pl != 0 ? 4 : 1)));
    chk({nm, "_bad_reads"}, 64'(bad_reads), 64'd0);
    if (ew == 0) chk({nm, "_cs_idle"}, 64'(cs_cycles), 64'd0);
    for (int i = 0; i < nw && i < wa.size(); i++) begin
      chk($sformatf("%s_addr%0d", nm, i), 64'(wa[i]), 64'(exp_a[i]));
      chk($sformatf("%s_data%0d", nm, i), 64'(wd[i]), 64'(exp_d[i]));
    end
  endtask

  typedef struct {
    logic [22:0] b;
    int ms, kn, pl, inj;
    int ew, ea;
  } vec_t;

  vec_t vt[9];

  task automatic fill_mem();
    for (int bk = 0; bk < NB; bk++)
      for (int i = 0; i < DEPTH; i++)
        mem[bk][i] = $urandom;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, n, cyc;
    vt[0] = '{23'h180000, 4, 2, 0, 0, 32, 1};
    vt[1] = '{23'h000100, 4, 1, 1, 0, 4, 1};
    vt[2] = '{23'h1803FE, 2, 1, 0, 0, 4, 2};
    vt[3] = '{23'h000010, 5, 4, 1, 0, 16, 1};
    vt[4] = '{23'h0003F0, 3, 3, 0, 0, 27, 2};
    vt[5] = '{23'h0001FF, 3, 0, 0, 0, 0, 0};
    vt[6] = '{23'h000000, 1, 2, 1, 0, 0, 0};
    vt[7] = '{23'h7FFFF8, 4, 1, 0, 0, 16, 2};
    vt[8] = '{23'h000200, 4, 2, 0, 1, 32, 1};

    pw = 0; wms = 1; wm = 0;
    start = 0; base_addr = '0; map_size = '0;
    kernel_num = '0; pooling = 0;
    fill_mem();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rd_en", 64'(sram_rd_en), 64'd0);
    chk("rst_cmd", 64'({CSn, RASn, CASn, WEn}), 64'h7F);
    chk("rst_A", 64'(A), 64'd0);
    chk("rst_D", 64'(D), 64'd0);
    rst = 1'b1;

    for (int i = 0; i < 9; i++) begin
      if (i == 1) begin
        mem[0][0] = -32'sd5;
        mem[0][1] = -32'sd3;
        mem[0][4] = -32'sd8;
        mem[0][5] = -32'sd1;
      end
      run_job($sformatf("v%0d", i), vt[i].b, vt[i].ms, vt[i].kn,
              vt[i].pl, vt[i].inj, vt[i].ew, vt[i].ea, lat);
      if (i == 0 && wa.size() == 32) begin
        chk("v0_first", 64'(wa[0]), 64'h180000);
        chk("v0_last", 64'(wa[31]), 64'h18001F);
        chk("v0_word17", 64'(wd[17]), 64'(mem[1][1]));
      end
      if (i == 1 && wd.size() > 0)
        chk("v1_pool_neg", 64'(wd[0]), 64'hFFFFFFFF);
      if (i == 2 && act_rows.size() == 2 && wa.size() == 4) begin
        chk("v2_row0", 64'(act_rows[0]), 64'h600);
        chk("v2_row1", 64'(act_rows[1]), 64'h601);
        chk("v2_col1", 64'(wa[1]), 64'h1803FF);
        chk("v2_col2", 64'(wa[2]), 64'h180400);
      end
      if (vt[i].ew == 0)
        chk($sformatf("v%0d_done_lat", i), 64'(lat <= 2), 64'd1);
    end

    // Reset landing on a column write.
    fill_mem();
    @(negedge clk);
    wa.delete();
    viol = 0;
    base_addr = 23'h000300; map_size = 10'd4;
    kernel_num = 10'd2; pooling = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(wa.size() >= 3 && !CASn) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("rstw_reached", 64'(cyc < 2000), 64'd1);
    rst = 1'b0;
    #1;
    chk("rstw_cmd", 64'({CSn, RASn, CASn, WEn}), 64'h7F);
    chk("rstw_busy", 64'(busy), 64'd0);
    chk("rstw_rd_en", 64'(sram_rd_en), 64'd0);
    n = wa.size();
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("rstw_no_writes", 64'(wa.size()), 64'(n));
    chk("rstw_idle", 64'(busy), 64'd0);
    run_job("after_rst", 23'h000300, 4, 2, 0, 0, 32, 1, lat);

    for (int j = 0; j < 10; j++) begin
      fill_mem();
      run_job($sformatf("rnd%0d", j),
              {13'($urandom_range(0, 8191)),
               10'(960 + $urandom_range(0, 63))},
              $urandom_range(1, 8), $urandom_range(0, 4),
              $urandom_range(0, 1), $urandom_range(0, 1),
              -1, -1, lat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/output_writeback_dma.md
Name: output_writeback_dma

Overview:
Moves finished output feature maps from the bank of per-kernel output SRAMs into DRAM over the RAS/CAS DRAM port. It generalises the fixed 32-bank write-back path: bank count, SRAM depth and DRAM timing are parametrised, and an optional 2x2/stride-2 signed max-pooling mode is applied on the fly. The block sits in top between the output SRAM array and the DRAM pins, and is started by the layer controller after the last channel pass completes.

Parameters:
NUM_BANKS, 32, number of output SRAM banks; one output channel per bank.
SRAM_DEPTH, 4096, words per bank; SRAM_AW = $clog2(SRAM_DEPTH).
COL_W, 10, DRAM column bits; word address = {row[12:0], col[COL_W-1:0]}.
T_RCD, 1, idle cycles between ACT and the first column write.
T_RP, 1, cycles RASn is held high for a precharge.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
start  in  1  one-cycle start pulse, sampled only in IDLE
base_addr  in  23  DRAM word address of output channel 0
map_size  in  10  output map edge as produced by the PE array
kernel_num  in  10  channels to write, 0..NUM_BANKS
pooling  in  1  0 = copy, 1 = 2x2 stride-2 signed max-pool
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at completion
sram_rd_en  out  1  SRAM read strobe
sram_bank  out  $clog2(NUM_BANKS)  bank select
sram_addr  out  SRAM_AW  word address within the bank
sram_rdata  in  32  read data, valid the cycle after sram_rd_en
CSn  out  1  DRAM chip select, active low
RASn  out  1  row address strobe, active low
CASn  out  1  column address strobe, active low
WEn  out  4  byte write enables, active low
A  out  13  row or column address
D  out  32  write data

Behaviour:
- Reset: all outputs deassert asynchronously and the FSM returns to IDLE.
  - busy = 0, done = 0, sram_rd_en = 0, CSn = RASn = CASn = 1, WEn = 4'hF, A = 0, D = 0.
  - The row-open flag clears.
- Inputs are latched at the accepted start. A start seen while busy is ignored.
- Output edge M:
  - M = map_size when pooling = 0.
  - M = map_size >> 1 when pooling = 1; an odd last row or column is dropped.
- Write order: channel-major, then y, then x.
  - DRAM address = base_addr + c*M*M + y*M + x, computed with an incremental counter (no multiplier).
- SRAM read addresses:
  - Copy mode: y*map_size + x.
  - Pool mode: the four taps (2y,2x), (2y,2x+1), (2y+1,2x), (2y+1,2x+1), issued in 4 consecutive cycles.
- Max-pool arithmetic: signed 32-bit compare; the first tap initialises the running max.
- FSM states:
  - IDLE: on start go to FETCH. If kernel_num = 0 or M = 0, go straight to DONE.
  - FETCH: issue 1 read (copy) or 4 reads (pool). The last data returns 1 cycle after the last read; then go to ROWCHK.
  - ROWCHK: if the row is open and equals addr[22:COL_W], go to WRITE. If another row is open, go to PRE. If no row is open, go to ACT.
  - PRE: RASn = 1, CSn = 0 for T_RP cycles; clear row-open; go to ACT.
  - ACT: for one cycle CSn = 0, RASn = 0, A = row; then hold RASn = 0 for T_RCD further cycles; set row-open; go to WRITE.
  - WRITE: for one cycle CASn = 0, WEn = 4'h0, A = {zero-pad, col}, D = word; then CASn = 1, WEn = 4'hF.
    - If more words remain, go to FETCH.
    - Otherwise go to PRE-final (T_RP cycles), then DONE.
  - DONE: done = 1 for one cycle, busy = 0, return to IDLE.
- RASn stays low while a row is open, and high otherwise.
- Address wrap: when the column overflows, the row changes, which forces PRE then ACT. No write ever crosses a row without an ACT.
- Words written = kernel_num*M*M exactly.

Decomposition:
- Shared package wb_pkg holds:
  - typedef dram_addr_t (23 bits);
  - the FSM state enum;
  - localparams ROW_W = 13 and DATA_W = 32;
  - function row_of/col_of.
- One natural sub-module: maxpool_acc. It is a 4-tap signed running-max register with clear, load and valid, and is bypassed in copy mode.

Test Plan:
1. NUM_BANKS = 4, map_size = 4, kernel_num = 2, pooling = 0, base = 0x180000 -> 32 CAS writes to 0x180000..0x18001F; word i equals bank[i/16][i%16]; one ACT (row 0x600); done pulses once.
2. pooling = 1, map_size = 4, kernel_num = 1, taps {-5,-3,-8,-1} at output (0,0) -> 4 writes; first write = 0xFFFFFFFF (-1); the others are the correct signed maxima.
3. base = 0x1803FE, map_size = 2, kernel_num = 1, copy -> writes to cols 0x3FE and 0x3FF in row 0x600, then RASn high for T_RP, ACT row 0x601, writes to cols 0 and 1.
4. Reset asserted during the WRITE state -> same cycle: CSn/RASn/CASn = 1, WEn = F, busy = 0; no further DRAM writes. A new start after release completes correctly.
5. start pulsed while busy -> ignored, with no change to the word count. kernel_num = 0 -> done pulses within 2 cycles, with no CSn activity.
6. pooling = 1, map_size = 5 -> M = 2, 4 writes per channel; row 4 and column 4 of the SRAM are never read.
